// File: rtl/instr_fetch_responder_if.sv
// Fetch-side bus bundle for instr_fetch_responder: the request/response
// handshake with the PC/fetch initiator, the flush strobe, and the
// synchronous instruction-memory read port.
//   slave  : the responder (drives req_ready, memory strobe, responses)
//   master : the initiator/memory side (drives requests, flush, mem_q, rsp_ready)
`timescale 1ns/1ps

interface instr_fetch_responder_if #(
   parameter int unsigned WORD_SIZE      = 32,
   parameter int unsigned MEM_ADDR_WIDTH = 16
);
   logic                      flush;
   logic                      req_valid;
   logic                      req_ready;
   logic [WORD_SIZE-1:0]      req_addr;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr;
   logic                      mem_rden;
   logic [WORD_SIZE-1:0]      mem_q;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [WORD_SIZE-1:0]      rsp_instr;
   logic [WORD_SIZE-1:0]      rsp_addr;
   logic                      rsp_fault;

   modport slave (
      input  flush, req_valid, req_addr, mem_q, rsp_ready,
      output req_ready, mem_addr, mem_rden, rsp_valid, rsp_instr, rsp_addr, rsp_fault
   );

   modport master (
      output flush, req_valid, req_addr, mem_q, rsp_ready,
      input  req_ready, mem_addr, mem_rden, rsp_valid, rsp_instr, rsp_addr, rsp_fault
   );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder. Accepts in-order fetch addresses, reads the
// 1-cycle-latency instruction memory, and returns instructions through a
// 2-entry response FIFO. Request-to-response latency is 2 cycles; one
// response per cycle is sustained while the consumer keeps rsp_ready high.
//
// Occupancy (buffered entries + in-flight read) never exceeds 2, so the
// FIFO cannot overflow: a new request is only taken while occupancy is
// below 2, or when the head is popping in the same cycle.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned addresses are accepted without a memory read and
//               answered with rsp_fault=1 and a NOP instruction.
//   undefined : the low two address bits are ignored and rsp_fault is 0.
`timescale 1ns/1ps

module instr_fetch_responder #(
   parameter int unsigned          WORD_SIZE      = 32,
   parameter int unsigned          MEM_ADDR_WIDTH = 16,
   parameter logic [WORD_SIZE-1:0] NOP_INSTR      = 32'h00000013
) (
   input  logic                      clk,
   input  logic                      rst,
   instr_fetch_responder_if.slave    io_fetch
);

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic C_TRAP_EN = 1'b1;
`else
   localparam logic C_TRAP_EN = 1'b0;
`endif

   // response FIFO storage
   logic [WORD_SIZE-1:0] r_buf_instr [2];
   logic [WORD_SIZE-1:0] r_buf_addr  [2];
   logic [1:0]           r_buf_fault;
   logic                 r_rd_ptr;
   logic                 r_wr_ptr;
   logic [1:0]           r_count;

   // the read issued last cycle whose data is on mem_q now
   logic                 r_inflight;
   logic [WORD_SIZE-1:0] r_if_addr;
   logic                 r_if_fault;

   logic [1:0]           w_occ;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_req_ready;
   logic                 w_accept;
   logic                 w_misalign;
   logic [WORD_SIZE-1:0] w_push_instr;
   logic                 w_unused_addr_bits;

   assign w_occ       = r_count + {1'b0, r_inflight};
   assign w_pop       = (r_count != 2'd0) && io_fetch.rsp_ready;
   assign w_push      = r_inflight;
   assign w_req_ready = rst && !io_fetch.flush && ((w_occ < 2'd2) || w_pop);
   assign w_accept    = io_fetch.req_valid && w_req_ready;
   assign w_misalign  = C_TRAP_EN && (io_fetch.req_addr[1:0] != 2'b00);

   // High address bits alias onto the same memory word.
   assign w_unused_addr_bits = ^io_fetch.req_addr[WORD_SIZE-1:MEM_ADDR_WIDTH+2];

   // Faulted fetches never read memory, so their data slot is the NOP.
   assign w_push_instr = r_if_fault ? NOP_INSTR : io_fetch.mem_q;

   assign io_fetch.req_ready = w_req_ready;
   assign io_fetch.mem_addr  = io_fetch.req_addr[MEM_ADDR_WIDTH+1:2];
   assign io_fetch.mem_rden  = w_accept && !w_misalign;

   assign io_fetch.rsp_valid = (r_count != 2'd0);
   assign io_fetch.rsp_instr = r_buf_instr[r_rd_ptr];
   assign io_fetch.rsp_addr  = r_buf_addr[r_rd_ptr];
   assign io_fetch.rsp_fault = C_TRAP_EN & r_buf_fault[r_rd_ptr];

   // In-flight slot: latch the accepted request for its data-return cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_inflight <= 1'b0;
         r_if_addr  <= '0;
         r_if_fault <= 1'b0;
      end else if (io_fetch.flush) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_accept;
         if (w_accept) begin
            r_if_addr  <= io_fetch.req_addr;
            r_if_fault <= w_misalign;
         end
      end
   end

   // FIFO pointers and count; flush drops everything including this cycle's push.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (io_fetch.flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO data: capture returning memory data (or fault NOP) at the tail.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            r_buf_instr[i] <= '0;
            r_buf_addr[i]  <= '0;
         end
         r_buf_fault <= 2'b00;
      end else if (w_push && !io_fetch.flush) begin
         r_buf_instr[r_wr_ptr] <= w_push_instr;
         r_buf_addr[r_wr_ptr]  <= r_if_addr;
         r_buf_fault[r_wr_ptr] <= r_if_fault;
      end
   end

   // A push into a full FIFO without a pop would lose an instruction.
   always_ff @(posedge clk) begin
      if (rst && !io_fetch.flush) begin
         assert (!(w_push && !w_pop && (r_count == 2'd2)));
      end
   end

endmodule
